uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Byte buffer sitting directly downstream of the UART receiver on the bit clock domain. Detects each completed frame (rising edge of the receiver's ready flag), captures the received byte into a DEPTH-entry FIFO, and presents bytes to the host over a valid/ready read port. Gates the receiver's enable when the buffer is full and keeps sticky overflow status plus a saturating drop counter.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥ 2
- AW, $clog2(DEPTH): pointer width (derived, not overridden)
- bclk  in  1  bit clock, shared with the receiver; all logic on posedge
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte from receiver; stable while rx_rdy = 1
- rx_rdy  in  1  receiver ready flag; 0 during a frame, 1 when idle or complete
- en  in  1  host enable for reception
- rx_en  out  1  enable to receiver: en & ~full (combinational)
- rd_data  out  8  head-of-FIFO byte; 8'h00 while empty
- rd_valid  out  1  head byte available (= ~empty)
- rd_ready  in  1  host accepts head byte
- clr  in  1  synchronous flush and status clear
- count  out  AW+1  bytes held, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky: at least one byte dropped
- ovf_cnt  out  8  dropped bytes, saturating at 255

## Operation
- Edge detect: register rdy_q <= rx_rdy each posedge; push = rx_rdy & ~rdy_q. rdy_q resets to 1, so the receiver's idle-high flag after reset never causes a push.
- Receiver updates on negedge bclk; rx_data and rx_rdy are sampled on posedge, half a cycle after change, so no extra sync stage.
- pop = rd_valid & rd_ready.
- Push when not full (or full with simultaneous pop): mem[wr_ptr] <= rx_data, wr_ptr++.
- Push when full and no pop: byte dropped, overflow <= 1, ovf_cnt++ unless 255. FIFO contents and pointers unchanged.
- Pop: rd_ptr++. Pop on empty impossible (rd_valid = 0); rd_ready ignored.
- Pointers AW bits, wrap modulo DEPTH; count tracked separately, +1 on push-only, −1 on pop-only, unchanged on push+pop.
- Push + pop on empty: not possible (no pop); push accepted.
- Push + pop on full: both accepted, count stays DEPTH, overflow not set.
- Priority: rst > clr > push/pop. clr: pointers, count, overflow, ovf_cnt to 0; a coincident push is discarded; rdy_q still updates.
- rd_data = mem[rd_ptr] when ~empty, else 8'h00 (memory array itself not reset).

## Timing
- Reset values: rd_valid 0, rd_data 8'h00, count 0, empty 1, full 0, overflow 0, ovf_cnt 0, rx_en = en; rdy_q 1.
- Latency: rx_rdy sampled 1 at posedge N (rdy_q = 0) → byte written at N; rd_valid/count visible after N. One push per rx_rdy rising edge, regardless of how long rx_rdy stays high.
- Read: first-word fall-through; rd_data valid same cycle as rd_valid; after pop at posedge M, next byte (or empty) visible after M.
- full/rx_en update the cycle after the filling push; a frame already started by the receiver before rx_en drops can still arrive and is dropped and counted.
- Reset mid-operation: all state cleared in one cycle; a frame in progress in the receiver is captured only if its rx_rdy rising edge occurs after reset deasserts.

## Structure
- uart_pkg: UART_DATA_W = 8, OVF_CNT_W = 8, OVF_CNT_MAX = 8'hFF; shared with receiver and future transmitter.
- Sub-module sync_fifo (parameters DATA_W, DEPTH): memory, pointers, count, full/empty, FWFT read. uart_rx_fifo wraps it with edge detect, drop logic, overflow status, rx_en.

## Test plan
- Reset, rx_rdy held 1 for 10 cycles → no push; count 0, empty 1, rd_valid 0, rd_data 00.
- Three frames 8'hA5, 8'h3C, 8'hFF (rx_rdy 0 for 9 cycles, then 1) → count 3; host reads with rd_ready = 1 → A5, 3C, FF in order, then empty.
- DEPTH = 16: 18 frames with rd_ready = 0 → full after 16th, rx_en 0, overflow 1, ovf_cnt 2, contents = first 16 bytes.
- Full FIFO, pop coincident with push of 8'h77 → count stays 16, overflow stays 0, 8'h77 read last.
- 300 dropped frames while full → ovf_cnt saturates at 255; clr → count 0, overflow 0, ovf_cnt 0.
- rst asserted with 5 bytes held and rx_rdy low mid-frame → all outputs at reset values; frame completing after reset is pushed as single byte.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART receiver, its RX byte buffer and the
// future transmitter.
//   UART_DATA_W - width of one UART character
//   OVF_CNT_W   - width of the saturating dropped-byte counter
//   OVF_CNT_MAX - value at which the dropped-byte counter saturates
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int OVF_CNT_W   = 8;
  localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = 8'hFF;

endpackage : uart_pkg

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word fall-through read.
//   clk     - clock, all state updates on posedge
//   rst     - synchronous active-high reset (pointers/count, not memory)
//   clr     - synchronous flush, same effect as rst on pointers/count
//   wr_en   - write request; accepted when not full or when a read coincides
//   wr_data - write data
//   rd_en   - read request; ignored while empty
//   rd_data - head entry, all-zeros while empty
//   count   - entries held, 0..DEPTH
//   empty   - count == 0
//   full    - count == DEPTH
//
// Handshake: a write happens on a posedge where wr_en is high and the FIFO is
// not full (or is full and a read happens in the same cycle); a read happens on
// a posedge where rd_en is high and the FIFO is not empty. The head entry is
// visible on rd_data in the same cycle it becomes available.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       count,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A read frees a slot in the same edge, so a write into a full FIFO is
  // accepted when it coincides with a read.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage is deliberately not reset; rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (do_wr && !rst && !clr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : sync_fifo

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte buffer downstream of the UART receiver, on the bit clock.
// Captures one byte per rising edge of the receiver's ready flag, holds up to
// DEPTH bytes and presents them to the host over a valid/ready read port.
//   bclk     - bit clock shared with the receiver
//   rst      - synchronous active-high reset
//   rx_data  - received byte, stable while rx_rdy is high
//   rx_rdy   - receiver ready flag (low during a frame, high when done/idle)
//   en       - host reception enable
//   rx_en    - receiver enable: en while the buffer has room
//   rd_data  - head byte, 8'h00 while empty
//   rd_valid - head byte available
//   rd_ready - host takes the head byte
//   clr      - synchronous flush plus status clear
//   count    - bytes held, 0..DEPTH
//   empty    - no bytes held
//   full     - DEPTH bytes held
//   overflow - sticky: at least one byte was dropped
//   ovf_cnt  - number of dropped bytes, saturating
//
// Read handshake: a byte is consumed on a posedge where rd_valid and rd_ready
// are both high; rd_ready has no effect while rd_valid is low.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                   bclk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_rdy,
  input  logic                   en,
  output logic                   rx_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  input  logic                   clr,
  output logic [AW:0]            count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic [OVF_CNT_W-1:0]   ovf_cnt
);

  logic rdy_q;
  logic push;
  logic pop;
  logic drop;

  // The receiver changes its outputs on negedge, so sampling on posedge is
  // already half a cycle clear of any transition; no synchroniser needed.
  // rdy_q starts high so the idle-high flag after reset is not a push.
  assign push = rx_rdy & ~rdy_q;
  assign pop  = rd_valid & rd_ready;
  // A byte is lost only when the buffer is full and no slot frees this edge.
  assign drop = push & full & ~pop;

  assign rd_valid = ~empty;
  assign rx_en    = en & ~full;

  sync_fifo #(
    .DATA_W (UART_DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (bclk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (push),
    .wr_data (rx_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  always_ff @(posedge bclk) begin
    if (rst) begin
      rdy_q    <= 1'b1;
      overflow <= 1'b0;
      ovf_cnt  <= '0;
    end else begin
      // Edge history keeps tracking during clr so a flag that stays high
      // across the flush is not seen as a new frame afterwards.
      rdy_q <= rx_rdy;
      if (clr) begin
        overflow <= 1'b0;
        ovf_cnt  <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (ovf_cnt != OVF_CNT_MAX) ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
      end
    end
  end

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: a table of single-cycle vectors followed by
// hand-written sequences for frames, fill/overflow, saturation, clr and reset.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  // ---------------- clock / reset ----------------
  logic       bclk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       en;
  logic       rx_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       clr;
  logic [AW:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic [7:0] ovf_cnt;

  always #5 bclk = ~bclk;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .bclk     (bclk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy),
    .en       (en),
    .rx_en    (rx_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .clr      (clr),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .ovf_cnt  (ovf_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic       m_ovf;
  int         m_ovf_cnt;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change just after negedge (like the receiver); outputs are read
  // there too, a half cycle after the posedge that updated them.
  task automatic tick();
    @(negedge bclk);
    #1;
  endtask

  // One receiver frame: rx_rdy low for low_cycles, then high with the byte.
  // With pop_too the host also takes the head byte on the completing edge.
  task automatic send_frame(input logic [7:0] b, input bit pop_too, input int low_cycles);
    rx_rdy = 1'b0;
    repeat (low_cycles) tick();
    rx_data = b;
    rx_rdy  = 1'b1;
    if (pop_too) begin
      check("pop_head", rd_data, exp_q[0]);
      rd_ready = 1'b1;
    end
    if (exp_q.size() < DEPTH || pop_too) begin
      if (pop_too) void'(exp_q.pop_front());
      exp_q.push_back(b);
    end else begin
      m_ovf = 1'b1;
      if (m_ovf_cnt < 255) m_ovf_cnt++;
    end
    tick();
    rd_ready = 1'b0;
  endtask

  // Read n bytes back with rd_ready held high, comparing against the queue.
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      check("rd_valid_drain", rd_valid, 1'b1);
      check("rd_data_drain", rd_data, exp_q[0]);
      void'(exp_q.pop_front());
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, count, exp_q.size());
    check({tag, "_overflow"}, overflow, m_ovf);
    check({tag, "_ovf_cnt"}, ovf_cnt, m_ovf_cnt);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_empty"}, empty, 1'b1);
    check({tag, "_full"}, full, 1'b0);
    check({tag, "_rd_valid"}, rd_valid, 1'b0);
    check({tag, "_rd_data"}, rd_data, 8'h00);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_ovf_cnt"}, ovf_cnt, 8'h00);
    check({tag, "_rx_en"}, rx_en, en);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       rdy;
    logic [7:0] data;
    logic       rrdy;
    logic       clr;
    logic [4:0] e_count;
    logic       e_valid;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // rdy  data   rrdy clr  count valid data
    vecs[0]  = '{1'b0, 8'h11, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 5'd1, 1'b1, 8'h11};
    vecs[2]  = '{1'b1, 8'h11, 1'b0, 1'b0, 5'd1, 1'b1, 8'h11};
    vecs[3]  = '{1'b0, 8'h22, 1'b0, 1'b0, 5'd1, 1'b1, 8'h11};
    vecs[4]  = '{1'b1, 8'h22, 1'b0, 1'b0, 5'd2, 1'b1, 8'h11};
    vecs[5]  = '{1'b1, 8'h22, 1'b1, 1'b0, 5'd1, 1'b1, 8'h22};
    vecs[6]  = '{1'b0, 8'h33, 1'b0, 1'b0, 5'd1, 1'b1, 8'h22};
    vecs[7]  = '{1'b1, 8'h33, 1'b1, 1'b0, 5'd1, 1'b1, 8'h33};
    vecs[8]  = '{1'b1, 8'h33, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};
    vecs[9]  = '{1'b1, 8'h33, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 8'h44, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00};
    vecs[11] = '{1'b1, 8'h44, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00};
    vecs[12] = '{1'b1, 8'h44, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00};
    vecs[13] = '{1'b0, 8'h55, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00};
    vecs[14] = '{1'b1, 8'h55, 1'b0, 1'b0, 5'd1, 1'b1, 8'h55};
    vecs[15] = '{1'b1, 8'h55, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};

    // ---------------- reset ----------------
    rst = 1'b1; clr = 1'b0; rx_rdy = 1'b1; rx_data = 8'h00;
    en = 1'b1; rd_ready = 1'b0;
    m_ovf = 1'b0; m_ovf_cnt = 0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    check_reset_vals("idle_after_reset");
    en = 1'b0;
    #1;
    check("rx_en_host_off", rx_en, 1'b0);
    en = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < 16; i++) begin
      rx_rdy = vecs[i].rdy; rx_data = vecs[i].data;
      rd_ready = vecs[i].rrdy; clr = vecs[i].clr;
      tick();
      check($sformatf("vec%0d_count", i), count, vecs[i].e_count);
      check($sformatf("vec%0d_valid", i), rd_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_data", i), rd_data, vecs[i].e_data);
      check($sformatf("vec%0d_overflow", i), overflow, 1'b0);
    end
    rd_ready = 1'b0; clr = 1'b0;

    // ---------------- three frames, read in order ----------------
    send_frame(8'hA5, 1'b0, 9);
    send_frame(8'h3C, 1'b0, 9);
    send_frame(8'hFF, 1'b0, 9);
    check("three_count", count, 3);
    drain(3);
    check("three_empty", empty, 1'b1);
    check("three_rd_data_empty", rd_data, 8'h00);

    // ---------------- fill past full ----------------
    for (int i = 0; i < 18; i++) begin
      send_frame(8'(i * 13 + 7), 1'b0, 3);
      if (i == 14) check("not_full_at_15", full, 1'b0);
      if (i == 15) begin
        check("full_at_16", full, 1'b1);
        check("rx_en_full", rx_en, 1'b0);
        check("no_ovf_at_16", overflow, 1'b0);
      end
    end
    check_status("after_18");
    check("ovf_cnt_2", ovf_cnt, 8'd2);
    drain(16);
    check("drained_empty", empty, 1'b1);
    check("rx_en_reopen", rx_en, 1'b1);

    // ---------------- clr, then push+pop while full ----------------
    clr = 1'b1; tick(); clr = 1'b0;
    m_ovf = 1'b0; m_ovf_cnt = 0;
    check_status("after_clr1");
    for (int i = 0; i < 16; i++) send_frame(8'(8'hC0 + i), 1'b0, 2);
    send_frame(8'h77, 1'b1, 2);
    check_status("push_pop_full");
    check("push_pop_full_flag", full, 1'b1);
    drain(16);
    check("push_pop_drained", empty, 1'b1);

    // ---------------- saturation and clr ----------------
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b0, 2);
    for (int i = 0; i < 300; i++) send_frame(8'hEE, 1'b0, 2);
    check_status("saturate");
    check("saturate_255", ovf_cnt, 8'hFF);
    clr = 1'b1; tick(); clr = 1'b0;
    exp_q.delete(); m_ovf = 1'b0; m_ovf_cnt = 0;
    check_reset_vals("after_clr2");

    // ---------------- reset mid-frame ----------------
    for (int i = 0; i < 5; i++) send_frame(8'(8'h90 + i), 1'b0, 3);
    check("five_count", count, 5);
    rx_rdy = 1'b0;
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    exp_q.delete();
    check_reset_vals("mid_reset");
    repeat (4) tick();
    rx_data = 8'h9A; rx_rdy = 1'b1;
    tick();
    check("post_reset_count", count, 1);
    check("post_reset_data", rd_data, 8'h9A);
    repeat (5) tick();
    check("post_reset_single", count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx_fifo
